// File: rtl/types_pkg.sv
// Shared ALU types: decoder op encoding, serial ALU FSM states and op helpers.
package types_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } aluop_e;

  typedef enum logic [1:0] {
    ALU_IDLE  = 2'd0,
    ALU_SHIFT = 2'd1,
    ALU_DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift_op(aluop_e op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/serial_shift_alu_if.sv
// Request/response bundle between the execute stage and the serial ALU.
interface serial_shift_alu_if #(parameter int XLEN = 32) ();
  import types_pkg::*;

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  aluop_e          alu_ctrl;
  logic            shift;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;

  modport master (
    output flush, in_valid, alu_ctrl, shift, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  flush, in_valid, alu_ctrl, shift, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero
  );

endinterface

// File: rtl/serial_shift_alu_comb.sv
// Purely combinational non-shift ALU datapath; shift encodings fall back to ADD.
module alu_comb
  import types_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  aluop_e          alu_ctrl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  always_comb begin
    y = a + b;
    case (alu_ctrl)
      ALU_SUB:  y = a - b;
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  y = a ^ b;
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = a + b;
    endcase
  end

endmodule

// File: rtl/serial_shift_alu.sv
// Execute-stage ALU: one-cycle registered non-shift ops, one-bit-per-cycle shifts,
// result returned over a valid/ready handshake.
//
// state     | meaning
// ALU_IDLE  | no result held, ready for a request
// ALU_SHIFT | serial shift in flight, cnt_q bits still to go
// ALU_DONE  | result/zero valid and held until out_ready
module serial_shift_alu
  import types_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input logic               clk,
  input logic               rst_n,
  serial_shift_alu_if.slave bus
);

  alu_state_e      state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_shifted;
  logic [XLEN-1:0] result_q, comb_y, accept_y;
  logic [SHW-1:0]  cnt_q, shamt;
  aluop_e          op_q;
  logic            zero_q;
  logic            in_ready_c, accept, req_shift, shift_to_done;
  logic            unused_hint;

  // The decoder hint is redundant with the op decode (it is also raised on branches).
  assign unused_hint = bus.shift;

  assign shamt     = bus.src_b[SHW-1:0];
  assign req_shift = is_shift_op(bus.alu_ctrl);
  assign accept    = bus.in_valid && in_ready_c && !bus.flush;
  assign accept_y  = req_shift ? bus.src_a : comb_y;
  assign shift_to_done = (state_q == ALU_SHIFT) && (cnt_q == SHW'(1));

  alu_comb #(.XLEN(XLEN)) u_alu_comb (
    .alu_ctrl (bus.alu_ctrl),
    .a        (bus.src_a),
    .b        (bus.src_b),
    .y        (comb_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ALU_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ALU_IDLE: begin
        if (accept) state_d = (req_shift && shamt != '0) ? ALU_SHIFT : ALU_DONE;
      end
      ALU_SHIFT: begin
        if (cnt_q == SHW'(1)) state_d = ALU_DONE;
      end
      ALU_DONE: begin
        if (accept)             state_d = (req_shift && shamt != '0) ? ALU_SHIFT : ALU_DONE;
        else if (bus.out_ready) state_d = ALU_IDLE;
      end
      default: state_d = ALU_IDLE;
    endcase
    if (bus.flush) state_d = ALU_IDLE;
  end

  always_comb begin
    in_ready_c    = (state_q == ALU_IDLE) || ((state_q == ALU_DONE) && bus.out_ready);
    bus.in_ready  = in_ready_c;
    bus.out_valid = (state_q == ALU_DONE);
    bus.result    = result_q;
    bus.zero      = zero_q;
  end

  always_comb begin
    case (op_q)
      ALU_SLL: acc_shifted = {acc_q[XLEN-2:0], 1'b0};
      ALU_SRA: acc_shifted = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
      default: acc_shifted = {1'b0, acc_q[XLEN-1:1]};
    endcase
  end

  // result_q only moves when a new result is produced, so it stays put under backpressure and flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      op_q     <= ALU_ADD;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else if (accept) begin
      op_q  <= bus.alu_ctrl;
      acc_q <= bus.src_a;
      cnt_q <= req_shift ? shamt : '0;
      if (!req_shift || shamt == '0) begin
        result_q <= accept_y;
        zero_q   <= (accept_y == '0);
      end
    end else if (state_q == ALU_SHIFT && !bus.flush) begin
      acc_q <= acc_shifted;
      cnt_q <= cnt_q - SHW'(1);
      if (shift_to_done) begin
        result_q <= acc_shifted;
        zero_q   <= (acc_shifted == '0);
      end
    end
  end

endmodule

// File: tb/tb_serial_shift_alu.sv
// Randomized and directed bench for serial_shift_alu against a transaction-level model.
module tb_serial_shift_alu;
  import types_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  serial_shift_alu_if #(.XLEN(32)) bus ();

  serial_shift_alu #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(aluop_e op, logic [31:0] a, logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << sh;
      ALU_SRL:  return a >> sh;
      ALU_SRA:  return 32'($signed(a) >>> sh);
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:  return a ^ b;
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return a + b;
    endcase
  endfunction

  function automatic int ref_latency(aluop_e op, logic [31:0] b);
    if (op == ALU_SLL || op == ALU_SRL || op == ALU_SRA) return 1 + int'(b % 32);
    return 1;
  endfunction

  // Called at a falling edge; returns at a falling edge with the result consumed.
  task automatic run_op(input aluop_e op, input logic hint, input logic [31:0] a,
                        input logic [31:0] b, input int hold, input string tag);
    logic [31:0] exp;
    int          exp_lat, lat;
    exp     = ref_result(op, a, b);
    exp_lat = ref_latency(op, b);
    bus.alu_ctrl  = op;
    bus.shift     = hint;
    bus.src_a     = a;
    bus.src_b     = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    #1 check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.src_a    = $urandom;
    bus.src_b    = $urandom;
    bus.alu_ctrl = ALU_AND;
    bus.shift    = 1'($urandom_range(0, 1));
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, bus.result, exp);
    check({tag, "_zero"}, 32'(bus.zero), 32'(exp == 32'd0));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_res"}, bus.result, exp);
      check({tag, "_hold_rdy"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_drain"}, 32'(bus.out_valid), 32'd0);
  endtask

  aluop_e      ops [11];
  logic [31:0] exp_q [$];
  int          seen;

  initial begin
    ops = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
            ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, aluop_e'(4'd12)};

    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b1;
    bus.alu_ctrl  = ALU_ADD;
    bus.shift     = 1'b0;
    bus.src_a     = 32'd3;
    bus.src_b     = 32'd4;
    bus.out_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_ov", 32'(bus.out_valid), 32'd0);
      check("rst_res", bus.result, 32'd0);
      check("rst_zero", 32'(bus.zero), 32'd1);
    end
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    #1 check("rst_rdy", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check("rst_noacc", 32'(bus.out_valid), 32'd0);

    run_op(ALU_SUB,  1'b0, 32'd5, 32'd5, 0, "sub_zero");
    run_op(ALU_SLT,  1'b0, 32'hFFFF_FFFF, 32'd1, 0, "slt");
    run_op(ALU_SLTU, 1'b0, 32'hFFFF_FFFF, 32'd1, 0, "sltu");
    run_op(ALU_SRA,  1'b1, 32'h8000_0000, 32'd4, 0, "sra4");
    run_op(ALU_SLL,  1'b1, 32'd1, 32'd31, 0, "sll31");
    run_op(ALU_SRL,  1'b1, 32'hDEAD_BEEF, 32'd0, 0, "srl0");
    run_op(ALU_SUB,  1'b1, 32'd7, 32'd3, 0, "branch_hint");
    run_op(ALU_SRL,  1'b0, 32'hF000_000F, 32'h0000_0104, 1, "srl_nohint");
    run_op(aluop_e'(4'd13), 1'b0, 32'd40, 32'd2, 0, "unlisted");

    // Backpressure then same-cycle chaining.
    bus.alu_ctrl = ALU_ADD; bus.shift = 1'b0; bus.src_a = 32'd10; bus.src_b = 32'd20;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp_valid", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_res", bus.result, 32'd30);
      check("bp_rdy", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    bus.alu_ctrl  = ALU_ADD; bus.src_a = 32'd100; bus.src_b = 32'd23;
    bus.in_valid  = 1'b1;
    #1 check("chain_rdy", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("chain_valid", 32'(bus.out_valid), 32'd1);
    check("chain_res", bus.result, 32'd123);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Back-to-back non-shift ops with out_ready held high.
    bus.out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        check("b2b_valid", 32'(bus.out_valid), 32'd1);
        check("b2b_res", bus.result, exp_q.pop_front());
      end
      if (i < 8) begin
        bus.alu_ctrl = ops[(i * 3) % 2 == 0 ? 0 : 1];
        bus.alu_ctrl = (i % 2 == 0) ? ALU_XOR : ALU_SUB;
        bus.src_a    = $urandom;
        bus.src_b    = $urandom;
        bus.in_valid = 1'b1;
        exp_q.push_back(ref_result(bus.alu_ctrl, bus.src_a, bus.src_b));
        #1 check("b2b_rdy", 32'(bus.in_ready), 32'd1);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    check("b2b_drain", 32'(bus.out_valid), 32'd0);

    // Flush mid-shift: no result may ever appear.
    bus.alu_ctrl = ALU_SLL; bus.shift = 1'b1; bus.src_a = 32'h0000_0003; bus.src_b = 32'd20;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_ov", 32'(bus.out_valid), 32'd0);
    check("flush_rdy", 32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("flush_noresult", 32'(seen), 32'd0);

    // Flush coincident with a request in IDLE drops the request.
    bus.alu_ctrl = ALU_ADD; bus.src_a = 32'd1; bus.src_b = 32'd1;
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("flush_drop", 32'(seen), 32'd0);

    // Reset in the middle of a shift.
    run_op(ALU_OR, 1'b0, 32'h0000_00F0, 32'h0000_0F00, 0, "pre_rst");
    bus.alu_ctrl = ALU_SLL; bus.src_a = 32'd5; bus.src_b = 32'd20;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_ov", 32'(bus.out_valid), 32'd0);
    check("midrst_res", bus.result, 32'd0);
    check("midrst_zero", 32'(bus.zero), 32'd1);
    check("midrst_rdy", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_idle", 32'(bus.out_valid), 32'd0);

    // Randomized operations with random backpressure.
    for (int i = 0; i < 50; i++) begin
      run_op(ops[$urandom_range(0, 10)], 1'($urandom_range(0, 1)), $urandom, $urandom,
             $urandom_range(0, 2), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
